// File: rtl/dlx_dmem_responder.sv
// DLX data-memory responder: valid/ready word read/write with a fixed response
// latency, internal word array and a snoop of the last committed write.
module dlx_dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] data_o,
    output logic [31:0] mem_addr_in_use_o,
    output logic [31:0] mem_addr_in_use_value_o
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mem [DEPTH];
    logic             r_we;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic             r_ack;
    logic             r_err_o;
    logic [31:0]      r_data_o;
    logic [31:0]      r_snp_adr;
    logic [31:0]      r_snp_dat;

    logic             w_accept;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic             w_resp_err;
    logic             w_resp_rd;
    logic [31:0]      w_resp_data;
    logic [31:0]      w_rd_word;

    assign w_accept  = req_i && (r_state == IDLE);
    assign w_idx     = adr_i[IDX_W+1:2];
    assign w_err     = (adr_i[1:0] != 2'b00) || ({2'b00, adr_i[31:2]} >= 32'(DEPTH));
    assign w_rd_word = (w_err || we_i) ? 32'h0000_0000 : r_mem[w_idx];

    // With LATENCY = 1 the response is formed straight from the accept edge,
    // otherwise from the values latched at acceptance.
    assign w_resp_err  = w_accept ? w_err : r_err;
    assign w_resp_rd   = w_accept ? !we_i : !r_we;
    assign w_resp_data = w_accept ? w_rd_word : r_rdata;

    assign ready_o                 = (r_state == IDLE);
    assign ack_o                   = r_ack;
    assign err_o                   = r_err_o;
    assign data_o                  = r_data_o;
    assign mem_addr_in_use_o       = r_snp_adr;
    assign mem_addr_in_use_value_o = r_snp_dat;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_i) begin
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched request, response and snoop registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_ack     <= 1'b0;
            r_err_o   <= 1'b0;
            r_data_o  <= 32'h0000_0000;
            r_snp_adr <= 32'h0000_0000;
            r_snp_dat <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= (w_state_nxt == RESP);
            r_err_o <= (w_state_nxt == RESP) ? w_resp_err : 1'b0;
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_we    <= we_i;
                r_err   <= w_err;
                r_rdata <= w_rd_word;
                if (we_i && !w_err) begin
                    r_snp_adr <= adr_i;
                    r_snp_dat <= data_i;
                end
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if ((w_state_nxt == RESP) && w_resp_rd) begin
                r_data_o <= w_resp_data;
            end
        end
    end

    // Word array: not cleared by reset, written only by error-free accepted writes
    always_ff @(posedge clock_i) begin
        if (!reset_i && w_accept && we_i && !w_err) begin
            r_mem[w_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_dlx_dmem_responder.sv
// Scoreboard bench for dlx_dmem_responder: one instance at LATENCY 2 and one at
// LATENCY 1, directed requests push expectations, a negedge monitor checks acks.
module tb_dlx_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_a, we_a, rdy_a, ack_a, err_a;
    logic [31:0] adr_a, wd_a, do_a, sa_a, sd_a;
    logic        rst_b, req_b, we_b, rdy_b, ack_b, err_b;
    logic [31:0] adr_b, wd_b, do_b, sa_b, sd_b;

    dlx_dmem_responder #(.DEPTH(256), .LATENCY(2)) dut_a (
        .clock_i(clk), .reset_i(rst_a), .req_i(req_a), .we_i(we_a),
        .adr_i(adr_a), .data_i(wd_a), .ready_o(rdy_a), .ack_o(ack_a),
        .err_o(err_a), .data_o(do_a), .mem_addr_in_use_o(sa_a),
        .mem_addr_in_use_value_o(sd_a)
    );

    dlx_dmem_responder #(.DEPTH(256), .LATENCY(1)) dut_b (
        .clock_i(clk), .reset_i(rst_b), .req_i(req_b), .we_i(we_b),
        .adr_i(adr_b), .data_i(wd_b), .ready_o(rdy_b), .ack_o(ack_b),
        .err_o(err_b), .data_o(do_b), .mem_addr_in_use_o(sa_b),
        .mem_addr_in_use_value_o(sd_b)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [31:0] sa;
        logic [31:0] sd;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] hold [2];
    logic [31:0] m_sa [2];
    logic [31:0] m_sd [2];
    int          lat  [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: every ack pops one expectation
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_ack", {31'b0, ack_a}, 32'h0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_err",  {31'b0, err_a}, {31'b0, e_a.err});
                chk("a_data", do_a, e_a.data);
                chk("a_snoop_adr", sa_a, e_a.sa);
                chk("a_snoop_dat", sd_a, e_a.sd);
                chk("a_ack_cycle", 32'(cyc), 32'(e_a.cyc));
            end
        end
        if (ack_b === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_ack", {31'b0, ack_b}, 32'h0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_err",  {31'b0, err_b}, {31'b0, e_b.err});
                chk("b_data", do_b, e_b.data);
                chk("b_snoop_adr", sa_b, e_b.sa);
                chk("b_snoop_dat", sd_b, e_b.sd);
                chk("b_ack_cycle", 32'(cyc), 32'(e_b.cyc));
            end
        end
    end

    function automatic logic rdy(input int s);
        return (s == 0) ? rdy_a : rdy_b;
    endfunction

    task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            req_a = r; we_a = w; adr_a = a; wd_a = d;
        end else begin
            req_b = r; we_b = w; adr_b = a; wd_b = d;
        end
    endtask

    task automatic push(input int s, input logic ee);
        exp_t e;
        e.err  = ee;
        e.data = hold[s];
        e.sa   = m_sa[s];
        e.sd   = m_sd[s];
        e.cyc  = cyc + lat[s];
        if (s == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // One transaction; called and returns at a negedge with the DUT idle
    task automatic issue(input int s, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic ee, input logic [31:0] rd);
        int n;
        n = 0;
        while (rdy(s) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_before_%0d_%h", s, a), {31'b0, rdy(s)}, 32'h1);
        drive(s, 1'b1, we, a, d);
        if (!we) hold[s] = ee ? 32'h0 : rd;
        if (we && !ee) begin
            m_sa[s] = a;
            m_sd[s] = d;
        end
        push(s, ee);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (rdy(s) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("busy_cycles_%0d_%h", s, a), 32'(n), 32'(lat[s]));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queues_empty", 32'(q_a.size() + q_b.size()), 32'h0);
    endtask

    initial begin
        int          n_acc;
        logic [31:0] a;
        logic [31:0] d;
        lat[0] = 2; lat[1] = 1;
        for (int i = 0; i < 2; i++) begin
            hold[i] = 32'h0; m_sa[i] = 32'h0; m_sd[i] = 32'h0;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, rdy_a}, 32'h1);
        chk("rst_ack",   {31'b0, ack_a}, 32'h0);
        chk("rst_err",   {31'b0, err_a}, 32'h0);
        chk("rst_data",  do_a, 32'h0);
        chk("rst_snoop_adr", sa_a, 32'h0);
        chk("rst_snoop_dat", sd_a, 32'h0);
        chk("rst_b_data", do_b, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        issue(0, 1'b1, 32'h13, 32'h1234, 1'b1, 32'h0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);

        // req_i held high for 6 cycles: only the idle-cycle samples are taken
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            a = (i % 2 == 0) ? 32'h0 : 32'h4;
            d = 32'hA0 + 32'(i);
            drive(0, 1'b1, 1'b1, a, d);
            if (rdy_a === 1'b1) begin
                m_sa[0] = a;
                m_sd[0] = d;
                push(0, 1'b0);
                n_acc++;
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("held_req_accepts", 32'(n_acc), 32'h2);
        drain();

        issue(0, 1'b1, 32'h404, 32'hBAD, 1'b1, 32'h0);
        issue(0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA0);
        issue(0, 1'b0, 32'h4, 32'h0, 1'b0, 32'hA3);

        // Reset while a write sits in WAIT: no ack, write stays committed
        drive(0, 1'b1, 1'b1, 32'h8, 32'h55);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_a = 1'b1;
        #1;
        chk("midrst_ack",  {31'b0, ack_a}, 32'h0);
        chk("midrst_err",  {31'b0, err_a}, 32'h0);
        chk("midrst_data", do_a, 32'h0);
        chk("midrst_snoop_adr", sa_a, 32'h0);
        chk("midrst_snoop_dat", sd_a, 32'h0);
        @(negedge clk);
        chk("midrst_ack_held", {31'b0, ack_a}, 32'h0);
        rst_a = 1'b0;
        hold[0] = 32'h0; m_sa[0] = 32'h0; m_sd[0] = 32'h0;
        @(negedge clk);
        chk("postrst_snoop_dat", sd_a, 32'h0);
        issue(0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h55);

        issue(1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0);
        issue(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5);

        drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
